// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracker giving forwarding selects/values and load-use stall
module hazard_scoreboard #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int DEPTH = 2,
    parameter int LATW  = 3,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  issue_valid,
    input  logic [RADDR-1:0]      issue_rd,
    input  logic [LATW-1:0]       issue_lat,
    input  logic [RADDR-1:0]      rs,
    input  logic [RADDR-1:0]      rt,
    input  logic [DEPTH*XLEN-1:0] stage_data,
    output logic                  stall,
    output logic                  fw1_en,
    output logic                  fw2_en,
    output logic [XLEN-1:0]       fw1,
    output logic [XLEN-1:0]       fw2,
    output logic [CNTW-1:0]       stall_count
);

    localparam logic [LATW-1:0] MAX_LAT = LATW'(DEPTH - 1);

    logic [DEPTH-1:0] slot_valid;
    logic [RADDR-1:0] slot_rd  [DEPTH];
    logic [LATW-1:0]  slot_lat [DEPTH];

    logic            hit1, hit2, rdy1, rdy2;
    logic [XLEN-1:0] val1, val2;
    logic [LATW-1:0] issue_lat_c;

    assign issue_lat_c = (issue_lat > MAX_LAT) ? MAX_LAT : issue_lat;

    // Scan oldest to youngest so the youngest matching slot overwrites older hits.
    always_comb begin
        hit1 = 1'b0;
        rdy1 = 1'b0;
        val1 = '0;
        hit2 = 1'b0;
        rdy2 = 1'b0;
        val2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_valid[k] && slot_rd[k] == rs && rs != '0) begin
                hit1 = 1'b1;
                rdy1 = (LATW'(k) >= slot_lat[k]);
                val1 = stage_data[k*XLEN +: XLEN];
            end
            if (slot_valid[k] && slot_rd[k] == rt && rt != '0) begin
                hit2 = 1'b1;
                rdy2 = (LATW'(k) >= slot_lat[k]);
                val2 = stage_data[k*XLEN +: XLEN];
            end
        end
    end

    assign fw1_en = hit1 && rdy1;
    assign fw2_en = hit2 && rdy2;
    assign fw1    = fw1_en ? val1 : '0;
    assign fw2    = fw2_en ? val2 : '0;
    assign stall  = (hit1 && !rdy1) || (hit2 && !rdy2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid  <= '0;
            stall_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_rd[k]  <= '0;
                slot_lat[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_rd[k]    <= slot_rd[k-1];
                slot_lat[k]   <= slot_lat[k-1];
            end
            // A stalled decode instruction is not accepted; a bubble enters execute.
            slot_valid[0] <= !stall && issue_valid && issue_rd != '0;
            slot_rd[0]    <= issue_rd;
            slot_lat[0]   <= issue_lat_c;
            if (stall && stall_count != {CNTW{1'b1}})
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard with queue-based reference model
module tb_hazard_scoreboard;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;
    localparam int DEPTH = 2;
    localparam int LATW  = 3;

    logic                  clk;
    logic                  reset;
    logic                  hold;
    logic                  issue_valid;
    logic [RADDR-1:0]      issue_rd;
    logic [LATW-1:0]       issue_lat;
    logic [RADDR-1:0]      rs, rt;
    logic [DEPTH*XLEN-1:0] stage_data;
    logic                  stall, fw1_en, fw2_en;
    logic [XLEN-1:0]       fw1, fw2;
    logic [15:0]           stall_count;
    logic                  s_stall, s_fw1_en, s_fw2_en;
    logic [XLEN-1:0]       s_fw1, s_fw2;
    logic [1:0]            s_count;

    hazard_scoreboard #(.XLEN(XLEN), .RADDR(RADDR), .DEPTH(DEPTH), .LATW(LATW), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .hold(hold), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_lat(issue_lat), .rs(rs), .rt(rt), .stage_data(stage_data), .stall(stall),
        .fw1_en(fw1_en), .fw2_en(fw2_en), .fw1(fw1), .fw2(fw2), .stall_count(stall_count)
    );

    hazard_scoreboard #(.XLEN(XLEN), .RADDR(RADDR), .DEPTH(DEPTH), .LATW(LATW), .CNTW(2)) dut_sat (
        .clk(clk), .reset(reset), .hold(hold), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_lat(issue_lat), .rs(rs), .rt(rt), .stage_data(stage_data), .stall(s_stall),
        .fw1_en(s_fw1_en), .fw2_en(s_fw2_en), .fw1(s_fw1), .fw2(s_fw2), .stall_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (!reset && !hold && issue_valid)
            assert (int'(issue_lat) <= DEPTH - 1) else $error("issue_lat %0d out of range", issue_lat);

    typedef struct {
        logic [RADDR-1:0] rd;
        int               lat;
        int               age;
    } ent_t;

    typedef struct {
        logic            stall;
        logic            fw1_en;
        logic [XLEN-1:0] fw1;
        logic            fw2_en;
        logic [XLEN-1:0] fw2;
        logic [15:0]     cnt16;
        logic [1:0]      cnt2;
    } exp_t;

    ent_t inflight[$];
    exp_t expq[$];
    int   m_cnt;
    int   n_total;
    int   n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    endtask

    // Youngest in-flight writer of s decides: ready once its age reaches its latency.
    function automatic void resolve(input logic [RADDR-1:0] s, input logic [DEPTH*XLEN-1:0] sd,
                                    output logic en, output logic [XLEN-1:0] v, output logic nr);
        int best;
        best = -1;
        en = 1'b0;
        v  = '0;
        nr = 1'b0;
        if (s != 0)
            foreach (inflight[i])
                if (inflight[i].rd == s && (best < 0 || inflight[i].age < inflight[best].age))
                    best = i;
        if (best >= 0) begin
            if (inflight[best].age >= inflight[best].lat) begin
                en = 1'b1;
                v  = sd[inflight[best].age*XLEN +: XLEN];
            end else begin
                nr = 1'b1;
            end
        end
    endfunction

    task automatic advance(input logic iv, input logic [RADDR-1:0] rd, input int lat,
                           input logic h, input logic st);
        ent_t nxt[$];
        ent_t ne;
        if (reset) begin
            inflight.delete();
            m_cnt = 0;
        end else if (!h) begin
            foreach (inflight[i])
                if (inflight[i].age + 1 < DEPTH) begin
                    ne = inflight[i];
                    ne.age++;
                    nxt.push_back(ne);
                end
            if (st) m_cnt++;
            else if (iv && rd != 0) begin
                ne.rd = rd;
                ne.lat = lat;
                ne.age = 0;
                nxt.push_front(ne);
            end
            inflight = nxt;
        end
    endtask

    task automatic predict();
        exp_t e;
        logic n1, n2;
        if (reset) begin
            inflight.delete();
            m_cnt = 0;
        end
        resolve(rs, stage_data, e.fw1_en, e.fw1, n1);
        resolve(rt, stage_data, e.fw2_en, e.fw2, n2);
        e.stall = n1 | n2;
        e.cnt16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
        e.cnt2  = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
        expq.push_back(e);
    endtask

    task automatic step(input logic iv, input logic [RADDR-1:0] rd, input int lat,
                        input logic [RADDR-1:0] s1, input logic [RADDR-1:0] s2, input logic h);
        logic st;
        issue_valid = iv;
        issue_rd    = rd;
        issue_lat   = LATW'(lat);
        rs          = s1;
        rt          = s2;
        hold        = h;
        stage_data  = {$urandom, $urandom};
        predict();
        st = expq[expq.size()-1].stall;
        @(posedge clk);
        advance(iv, rd, lat, h, st);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall",           64'(stall),       64'(e.stall));
                chk("fw1_en",          64'(fw1_en),      64'(e.fw1_en));
                chk("fw1",             64'(fw1),         64'(e.fw1));
                chk("fw2_en",          64'(fw2_en),      64'(e.fw2_en));
                chk("fw2",             64'(fw2),         64'(e.fw2));
                chk("stall_count",     64'(stall_count), 64'(e.cnt16));
                chk("stall_count_sat", 64'(s_count),     64'(e.cnt2));
            end
        end
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        m_cnt   = 0;
        reset = 1'b1;
        hold = 1'b0;
        issue_valid = 1'b0;
        issue_rd = '0;
        issue_lat = '0;
        rs = 5'd5;
        rt = 5'd5;
        stage_data = '0;
        @(posedge clk);
        #1;
        step(1, 5'd5, 0, 5'd5, 5'd5, 0);
        step(1, 5'd5, 0, 5'd5, 5'd5, 0);
        reset = 1'b0;
        step(0, 5'd0, 0, 5'd5, 5'd5, 0);
        step(0, 5'd0, 0, 5'd5, 5'd5, 0);
        // ALU producer forwarded from slot 0 then slot 1
        step(1, 5'd3, 0, 5'd0, 5'd0, 0);
        step(0, 5'd0, 0, 5'd3, 5'd0, 0);
        step(0, 5'd0, 0, 5'd3, 5'd3, 0);
        // load-use: one stall then forward from slot 1
        step(1, 5'd4, 1, 5'd0, 5'd0, 0);
        step(0, 5'd0, 0, 5'd0, 5'd4, 0);
        step(0, 5'd0, 0, 5'd0, 5'd4, 0);
        // two writers of r7: the youngest wins
        step(1, 5'd7, 0, 5'd0, 5'd0, 0);
        step(1, 5'd7, 0, 5'd0, 5'd0, 0);
        step(0, 5'd0, 0, 5'd7, 5'd7, 0);
        // r0 is never tracked
        step(1, 5'd0, 0, 5'd0, 5'd0, 0);
        step(0, 5'd0, 0, 5'd0, 5'd0, 0);
        // hold during a pending load stall
        step(1, 5'd9, 1, 5'd0, 5'd0, 0);
        step(1, 5'd12, 0, 5'd0, 5'd9, 1);
        step(1, 5'd12, 0, 5'd0, 5'd9, 1);
        step(1, 5'd12, 0, 5'd0, 5'd9, 1);
        step(1, 5'd12, 0, 5'd0, 5'd9, 0);
        step(1, 5'd12, 0, 5'd9, 5'd9, 0);
        step(0, 5'd0, 0, 5'd12, 5'd9, 0);
        // five more load-use stalls drive the 2-bit counter into saturation
        for (int i = 0; i < 5; i++) begin
            step(1, 5'd10, 1, 5'd0, 5'd0, 0);
            step(0, 5'd0, 0, 5'd10, 5'd0, 0);
        end
        // asynchronous reset between edges with two valid slots
        step(1, 5'd11, 0, 5'd0, 5'd0, 0);
        step(1, 5'd13, 0, 5'd0, 5'd0, 0);
        issue_valid = 1'b0;
        rs = 5'd11;
        rt = 5'd13;
        stage_data = {$urandom, $urandom};
        inflight.delete();
        m_cnt = 0;
        predict();
        #2 reset = 1'b1;
        @(posedge clk);
        advance(0, 5'd0, 0, 0, 0);
        #1;
        step(0, 5'd0, 0, 5'd11, 5'd13, 0);
        reset = 1'b0;
        step(0, 5'd0, 0, 5'd11, 5'd13, 0);
        // randomized traffic with frequent register collisions
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, DEPTH - 1),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(0, 4) == 0);
        repeat (2) @(posedge clk);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding tracker for the MIPS pipeline cores, the next generation of the fixed two-stage load-use/forwarding logic. Records the destination register, remaining latency and validity of every in-flight instruction between decode and writeback in a DEPTH-slot shift register. Returns forwarding selects and values for the two decode-stage source operands, and a load-use style stall for any producer whose result is not yet available. Adds a memory-hold freeze for multi-cycle memory and a saturating stall counter.

## Interface
- XLEN, 32: data width.
- RADDR, 5: register address width; register 0 is never tracked.
- DEPTH, 2: in-flight slots; slot 0 = execute, slot DEPTH-1 = last stage before writeback. Legal range 1..8.
- LATW, 3: width of latency field; must hold DEPTH-1.
- CNTW, 16: stall counter width.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- hold  in  1  external memory wait; freezes all state this cycle.
- issue_valid  in  1  decode has an instruction writing issue_rd.
- issue_rd  in  RADDR  destination register of decode instruction.
- issue_lat  in  LATW  slot index at which its result first becomes valid (0 = ALU, 1 = load with DEPTH 2).
- rs, rt  in  RADDR  decode source registers.
- stage_data  in  DEPTH*XLEN  slot k result at bits [k*XLEN +: XLEN], combinational from stage k this cycle.
- stall  out  1  decode must hold; a bubble enters slot 0.
- fw1_en, fw2_en  out  1  forward for rs / rt instead of register file.
- fw1, fw2  out  XLEN  forwarded values; 0 when corresponding enable is 0.
- stall_count  out  CNTW  number of stall cycles since reset, saturating.

## Operation
- Slot state per k: valid, rd, lat. Slot valid only if its issue_valid was 1 and issue_rd != 0.
- Match for source s: slot k valid and rd == s and s != 0. If several slots match, the lowest k (youngest) wins; older matches are ignored.
- Winning slot k with k >= lat: forward; fwN_en=1, fwN = stage_data[k].
- Winning slot k with k < lat: not ready; stall=1, fwN_en=0.
- No match: fwN_en=0, fwN=0.
- stall = not-ready(rs) OR not-ready(rt). stall is independent of hold.
- Shift, when hold=0: slot[k] <= slot[k-1] for k>=1. slot[0] <= bubble (valid=0) if stall, otherwise {issue_valid && issue_rd!=0, issue_rd, issue_lat}. The oldest slot is discarded; its register-file write is visible to decode the following cycle.
- When hold=1: no slot moves and stall_count does not change. Outputs still track inputs combinationally.
- stall_count increments on each cycle with stall=1 and hold=0. It stops at 2^CNTW-1.
- issue_lat > DEPTH-1 is illegal. The bench flags it with an assertion. The RTL treats it as DEPTH-1.

## Timing
- Reset: all slots invalid, stall_count=0. Outputs read stall=0, fw1_en=fw2_en=0, fw1=fw2=0 while reset is asserted and after release until an issue occurs.
- Reset asserted mid-operation clears slots immediately, asynchronously. It does not wait for a clock edge.
- Forwarding and stall are purely combinational from slot state, rs, rt and stage_data. There is zero cycle latency to outputs.
- A producer issued at edge N occupies slot k after edge N+k+1, counting only edges with hold=0.
- A load with lat=1 followed by a dependent instruction gives exactly 1 stall cycle when DEPTH=2. The dependent instruction then forwards from slot 1.
- Simultaneous hold=1 and stall=1: no bubble is inserted and no count is taken. The stall persists until hold drops.

## Test plan
- Reset, then idle with rs=rt=5 -> stall=0, fw1_en=fw2_en=0, stall_count=0.
- ALU issue rd=3 lat=0, next cycle rs=3 with stage_data slot0=0x1234 -> fw1_en=1, fw1=0x1234, stall=0. One cycle later, slot1=0x1234 -> still forwarded from slot 1.
- Load rd=4 lat=1, next cycle rt=4 -> stall=1 for one cycle, stall_count=1. Next cycle fw2=stage_data slot1.
- Two producers of rd=7: older in slot 1 = 0xAAAA, younger in slot 0 = 0xBBBB -> fw1=0xBBBB. With issue_rd=0, or with rs=rt=0, no valid slot is created and no forward occurs.
- Hold=1 for 3 cycles during a pending load stall -> slots frozen, stall stays 1, stall_count unchanged. Release -> one counted stall, then forward.
- Reset pulsed asynchronously between edges with two valid slots -> outputs clear before the next edge. CNTW=2 with 5 stalls -> stall_count=3.
